fetch_sequencer: RTL

- Program-counter controller sitting between the instruction ROM and the branch-target lookup table.
- Sequences instruction fetch from a start address, and redirects on taken branches. The 5-bit branch pointer is driven to the lookup table and its 12-bit absolute target is loaded.
- Handles halt and stall, and reports Done/Busy to the top-level testbench handshake.
- One program runs per Start pulse.

---
 rtl/fetch_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter controller between the instruction ROM and
// the branch-target lookup table. Fetches sequentially from a start address,
// redirects through the lookup table on taken branches (one bubble cycle),
// and reports Busy/Done for the surrounding handshake.
//
// Optional return stack: define FETCH_SEQ_CALL_STACK_EN to enable Call/Ret
// handling backed by a RAS_DEPTH-entry return-address stack. Without the
// macro, Call and Ret are ignored and no stack storage exists.

module fetch_sequencer #(
   parameter int PC_W        = 12,
   parameter int PTR_W       = 5,
   parameter int NUM_TARGETS = 18,
   parameter int RAS_DEPTH   = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [PC_W-1:0]  StartAddr,
   input  logic             Stall,
   input  logic             Halt,
   input  logic             BranchEn,
   input  logic [PTR_W-1:0] BranchPtr,
   output logic [PTR_W-1:0] LutAddr,
   input  logic [PC_W-1:0]  LutTarget,
   input  logic             Call,
   input  logic             Ret,
   output logic [PC_W-1:0]  ProgCtr,
   output logic             Fetch,
   output logic             Busy,
   output logic             Done,
   output logic             BadTarget
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      REDIRECT,
      HALTED
   } state_t;

   state_t           state_q, state_d;
   logic [PC_W-1:0]  progCtr_q, progCtr_d;
   logic [PTR_W-1:0] lutAddr_q, lutAddr_d;
   logic             done_q, done_d;
   logic             badTarget_q, badTarget_d;
   logic             ptrLegal;

   assign ptrLegal = (BranchPtr < PTR_W'(NUM_TARGETS));

`ifdef FETCH_SEQ_CALL_STACK_EN
   localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);
   localparam int IDX_W     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

   logic [PC_W-1:0]      retStack_q [RAS_DEPTH];
   logic [RAS_CNT_W-1:0] rasCnt_q, rasCnt_d;
   logic                 pushEn;
   logic [IDX_W-1:0]     pushIdx;
   logic [IDX_W-1:0]     popIdx;

   // The stack grows upward: the count is the next free slot, count-1 the top.
   assign pushIdx = IDX_W'(rasCnt_q);
   assign popIdx  = IDX_W'(rasCnt_q - 1'b1);

   // Return-address storage; written only on a successful Call.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < RAS_DEPTH; i++) begin
            retStack_q[i] <= '0;
         end
      end else if (pushEn) begin
         retStack_q[pushIdx] <= progCtr_q + 1'b1;
      end
   end

   // Stack occupancy counter.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rasCnt_q <= '0;
      end else begin
         rasCnt_q <= rasCnt_d;
      end
   end
`else
   logic unusedCallRet;

   assign unusedCallRet = Call ^ Ret;
`endif

   // State and datapath registers; Reset aborts any program with no Done.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         progCtr_q   <= '0;
         lutAddr_q   <= '0;
         done_q      <= 1'b0;
         badTarget_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         progCtr_q   <= progCtr_d;
         lutAddr_q   <= lutAddr_d;
         done_q      <= done_d;
         badTarget_q <= badTarget_d;
      end
   end

   // Next-state logic. In RUN the order is Stall, Halt, (Ret, Call,) BranchEn,
   // then sequential increment; a fault always lands in HALTED with Done set.
   always_comb begin
      state_d     = state_q;
      progCtr_d   = progCtr_q;
      lutAddr_d   = lutAddr_q;
      done_d      = done_q;
      badTarget_d = badTarget_q;
`ifdef FETCH_SEQ_CALL_STACK_EN
      rasCnt_d    = rasCnt_q;
      pushEn      = 1'b0;
`endif
      case (state_q)
         IDLE, HALTED: begin
            if (Start) begin
               progCtr_d   = StartAddr;
               done_d      = 1'b0;
               badTarget_d = 1'b0;
               state_d     = RUN;
`ifdef FETCH_SEQ_CALL_STACK_EN
               rasCnt_d    = '0;
`endif
            end
         end
         RUN: begin
            if (Stall) begin
               state_d = RUN;
            end else if (Halt) begin
               done_d  = 1'b1;
               state_d = HALTED;
            end
`ifdef FETCH_SEQ_CALL_STACK_EN
            else if (Ret) begin
               if (rasCnt_q == '0) begin
                  badTarget_d = 1'b1;
                  done_d      = 1'b1;
                  state_d     = HALTED;
               end else begin
                  progCtr_d = retStack_q[popIdx];
                  rasCnt_d  = rasCnt_q - 1'b1;
               end
            end else if (Call) begin
               if (rasCnt_q == RAS_CNT_W'(RAS_DEPTH) || !ptrLegal) begin
                  badTarget_d = 1'b1;
                  done_d      = 1'b1;
                  state_d     = HALTED;
               end else begin
                  pushEn    = 1'b1;
                  rasCnt_d  = rasCnt_q + 1'b1;
                  lutAddr_d = BranchPtr;
                  state_d   = REDIRECT;
               end
            end
`endif
            else if (BranchEn) begin
               if (ptrLegal) begin
                  lutAddr_d = BranchPtr;
                  state_d   = REDIRECT;
               end else begin
                  badTarget_d = 1'b1;
                  done_d      = 1'b1;
                  state_d     = HALTED;
               end
            end else begin
               progCtr_d = progCtr_q + 1'b1;
            end
         end
         REDIRECT: begin
            if (!Stall) begin
               progCtr_d = LutTarget;
               state_d   = RUN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Status outputs follow directly from the current state.
   always_comb begin
      Fetch = (state_q == RUN);
      Busy  = (state_q == RUN) || (state_q == REDIRECT);
   end

   assign ProgCtr   = progCtr_q;
   assign LutAddr   = lutAddr_q;
   assign Done      = done_q;
   assign BadTarget = badTarget_q;

endmodule
